// File: rtl/fifo_pkg.sv
// Shared types, width helpers and parameter legality checks for the parametrised sync FIFO.
package fifo_pkg;

    localparam int MIN_DEPTH = 4;

    // Accept pattern of one cycle, {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    // One extra bit so the count can hold DEPTH itself.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit depth_ok(input int depth);
        return is_pow2(depth) && (depth >= MIN_DEPTH);
    endfunction

    function automatic bit th_ok(input int th, input int depth);
        return (th >= 1) && (th <= depth - 1);
    endfunction

    function automatic bit params_ok(input int depth, input int afull_th, input int aempty_th);
        return depth_ok(depth) && th_ok(afull_th, depth) && th_ok(aempty_th, depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer side of the parametrised sync FIFO; the FIFO takes the slave modport.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic              i_w_en;
    logic [DATA_W-1:0] i_data;
    logic              i_r_en;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_buf_full;
    logic              o_buf_empty;
    logic              o_almost_full;
    logic              o_almost_empty;
    logic [CNT_W-1:0]  o_fifo_cnt;

    // Requests are plain enables: a write is taken when not full, a read when not empty;
    // o_valid pulses for one cycle, one cycle after each accepted read.
    modport master (
        output i_w_en, i_data, i_r_en,
        input  o_data, o_valid, o_buf_full, o_buf_empty,
        input  o_almost_full, o_almost_empty, o_fifo_cnt
    );

    modport slave (
        input  i_w_en, i_data, i_r_en,
        output o_data, o_valid, o_buf_full, o_buf_empty,
        output o_almost_full, o_almost_empty, o_fifo_cnt
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read with enable.
// USE_BRAM picks block or distributed RAM through the ram_style attribute.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  DEPTH    = 16,
    parameter int  USE_BRAM = 1,
    localparam int AW       = ptr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              w_en_i,
    input  logic [AW-1:0]     w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              r_en_i,
    input  logic [AW-1:0]     r_addr_i,
    output logic [DATA_W-1:0] r_data_o
);

    logic [DATA_W-1:0] r_data_q;

    // Only the read register is reset; the array itself never is.
    if (USE_BRAM != 0) begin : g_bram
        (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

        always_ff @(posedge clk_i) begin
            if (w_en_i) begin
                mem[w_addr_i] <= w_data_i;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_data_q <= '0;
            end else if (r_en_i) begin
                r_data_q <= mem[r_addr_i];
            end
        end
    end else begin : g_lutram
        (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];

        always_ff @(posedge clk_i) begin
            if (w_en_i) begin
                mem[w_addr_i] <= w_data_i;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_data_q <= '0;
            end else if (r_en_i) begin
                r_data_q <= mem[r_addr_i];
            end
        end
    end

    assign r_data_o = r_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact registered flags, thresholds and occupancy.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky o_overflow / o_underflow outputs.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4,
    parameter int USE_BRAM  = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    sync_fifo_param_if.slave bus
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic o_overflow,
    output logic o_underflow
`endif
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [AW-1:0]     w_ptr_q, w_ptr_d;
    logic [AW-1:0]     r_ptr_q, r_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              valid_q, valid_d;
    logic              wr_ok, rd_ok;
    fifo_op_e          op;
    logic [DATA_W-1:0] rdata;

    p_params_legal: assert property (@(posedge i_clk) params_ok(DEPTH, AFULL_TH, AEMPTY_TH));

    assign wr_ok = bus.i_w_en & ~full_q;
    assign rd_ok = bus.i_r_en & ~empty_q;
    assign op    = fifo_op_e'({wr_ok, rd_ok});

    // Flags come from the next count so they change in the same cycle as o_fifo_cnt.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        cnt_d   = cnt_q;
        case (op)
            OP_WRITE: begin
                w_ptr_d = w_ptr_q + AW'(1);
                cnt_d   = cnt_q + CW'(1);
            end
            OP_READ: begin
                r_ptr_d = r_ptr_q + AW'(1);
                cnt_d   = cnt_q - CW'(1);
            end
            OP_BOTH: begin
                w_ptr_d = w_ptr_q + AW'(1);
                r_ptr_d = r_ptr_q + AW'(1);
            end
            default: begin
            end
        endcase
        full_d   = (cnt_d == DEPTH_C);
        empty_d  = (cnt_d == '0);
        afull_d  = (cnt_d >= AFULL_C);
        aempty_d = (cnt_d <= AEMPTY_C);
        valid_d  = rd_ok;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            w_ptr_q  <= w_ptr_d;
            r_ptr_q  <= r_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            valid_q  <= valid_d;
        end
    end

    fifo_ram #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .USE_BRAM (USE_BRAM)
    ) u_ram (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .w_en_i   (wr_ok),
        .w_addr_i (w_ptr_q),
        .w_data_i (bus.i_data),
        .r_en_i   (rd_ok),
        .r_addr_i (r_ptr_q),
        .r_data_o (rdata)
    );

    assign bus.o_data         = rdata;
    assign bus.o_valid        = valid_q;
    assign bus.o_buf_full     = full_q;
    assign bus.o_buf_empty    = empty_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_almost_empty = aempty_q;
    assign bus.o_fifo_cnt     = cnt_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    // Sticky until reset so a monitor can poll them at leisure.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.i_w_en & full_q) begin
                ovf_q <= 1'b1;
            end
            if (bus.i_r_en & empty_q) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
`endif

endmodule
